// File: rtl/lcd_ctrl.sv
// lcd_ctrl: loads an 8x8 8-bit image from IROM, applies window commands around a
// movable operation point, then streams the image out to IRAM.
module lcd_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cmd,
  input  logic       cmd_valid,
  output logic       IROM_rd,
  output logic [5:0] IROM_A,
  input  logic [7:0] IROM_Q,
  output logic       IRAM_valid,
  output logic [7:0] IRAM_D,
  output logic [5:0] IRAM_A,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {StLoad, StIdle, StExec, StWrite, StDone} state_e;

  state_e      state_q, state_d;
  logic        rom_rd_q, rom_rd_d;
  logic [5:0]  rom_a_q, rom_a_d;
  logic        ram_valid_q, ram_valid_d;
  logic [5:0]  ram_a_q, ram_a_d;
  logic [7:0]  ram_d_q, ram_d_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [2:0]  x_q, x_d, y_q, y_d;
  logic [3:0]  cmd_q, cmd_d;

  logic [7:0]  mem [64];
  logic        load_we, win_we;

  // Window addresses: row in the upper three bits, column in the lower three.
  logic [2:0]  xm1, ym1;
  logic [5:0]  a0, a1, a2, a3;
  logic [7:0]  p0, p1, p2, p3;
  logic [7:0]  n0, n1, n2, n3;
  logic [7:0]  mx01, mx23, mx_all, mn01, mn23, mn_all;
  logic [9:0]  sum;

  assign xm1 = x_q - 3'd1;
  assign ym1 = y_q - 3'd1;
  assign a0  = {ym1, xm1};
  assign a1  = {ym1, x_q};
  assign a2  = {y_q, xm1};
  assign a3  = {y_q, x_q};
  assign p0  = mem[a0];
  assign p1  = mem[a1];
  assign p2  = mem[a2];
  assign p3  = mem[a3];

  assign IROM_rd    = rom_rd_q;
  assign IROM_A     = rom_a_q;
  assign IRAM_valid = ram_valid_q;
  assign IRAM_A     = ram_a_q;
  assign IRAM_D     = ram_d_q;
  assign busy       = busy_q;
  assign done       = done_q;

  // Pixel-command results for the current window.
  always_comb begin
    mx01   = (p0 > p1) ? p0 : p1;
    mx23   = (p2 > p3) ? p2 : p3;
    mx_all = (mx01 > mx23) ? mx01 : mx23;
    mn01   = (p0 < p1) ? p0 : p1;
    mn23   = (p2 < p3) ? p2 : p3;
    mn_all = (mn01 < mn23) ? mn01 : mn23;
    sum    = {2'b00, p0} + {2'b00, p1} + {2'b00, p2} + {2'b00, p3};
    n0 = p0;
    n1 = p1;
    n2 = p2;
    n3 = p3;
    case (cmd_q)
      4'h5: begin n0 = mx_all; n1 = mx_all; n2 = mx_all; n3 = mx_all; end
      4'h6: begin n0 = mn_all; n1 = mn_all; n2 = mn_all; n3 = mn_all; end
      4'h7: begin n0 = sum[9:2]; n1 = sum[9:2]; n2 = sum[9:2]; n3 = sum[9:2]; end
      4'h8: begin n0 = p1; n1 = p3; n2 = p0; n3 = p2; end
      4'h9: begin n0 = p2; n1 = p0; n2 = p3; n3 = p1; end
      4'hA: begin n0 = p2; n1 = p3; n2 = p0; n3 = p1; end
      4'hB: begin n0 = p1; n1 = p0; n2 = p3; n3 = p2; end
      default: ;
    endcase
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    rom_rd_d    = rom_rd_q;
    rom_a_d     = rom_a_q;
    ram_valid_d = ram_valid_q;
    ram_a_d     = ram_a_q;
    ram_d_d     = ram_d_q;
    busy_d      = busy_q;
    done_d      = done_q;
    x_d         = x_q;
    y_d         = y_q;
    cmd_d       = cmd_q;
    load_we     = 1'b0;
    win_we      = 1'b0;
    case (state_q)
      StLoad: begin
        // First cycle only raises the read; capture starts once data has been fetched.
        rom_rd_d = 1'b1;
        if (rom_rd_q) begin
          load_we = 1'b1;
          if (rom_a_q == 6'd63) begin
            rom_rd_d = 1'b0;
            busy_d   = 1'b0;
            state_d  = StIdle;
          end else begin
            rom_a_d = rom_a_q + 6'd1;
          end
        end
      end
      StIdle: begin
        if (cmd_valid && !busy_q) begin
          cmd_d   = cmd;
          busy_d  = 1'b1;
          state_d = StExec;
        end
      end
      StExec: begin
        busy_d  = 1'b0;
        state_d = StIdle;
        case (cmd_q)
          4'h0: begin
            busy_d      = 1'b1;
            state_d     = StWrite;
            ram_valid_d = 1'b1;
            ram_a_d     = 6'd0;
            ram_d_d     = mem[0];
          end
          4'h1: if (y_q > 3'd1) y_d = y_q - 3'd1;
          4'h2: if (y_q < 3'd7) y_d = y_q + 3'd1;
          4'h3: if (x_q > 3'd1) x_d = x_q - 3'd1;
          4'h4: if (x_q < 3'd7) x_d = x_q + 3'd1;
          4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hB: win_we = 1'b1;
          default: ;
        endcase
      end
      StWrite: begin
        if (ram_a_q == 6'd63) begin
          ram_valid_d = 1'b0;
          done_d      = 1'b1;
          state_d     = StDone;
        end else begin
          ram_a_d = ram_a_q + 6'd1;
          ram_d_d = mem[ram_a_q + 6'd1];
        end
      end
      StDone: ;
      default: state_d = StLoad;
    endcase
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StLoad;
      rom_rd_q    <= 1'b0;
      rom_a_q     <= 6'd0;
      ram_valid_q <= 1'b0;
      ram_a_q     <= 6'd0;
      ram_d_q     <= 8'd0;
      busy_q      <= 1'b1;
      done_q      <= 1'b0;
      x_q         <= 3'd4;
      y_q         <= 3'd4;
      cmd_q       <= 4'd0;
    end else begin
      state_q     <= state_d;
      rom_rd_q    <= rom_rd_d;
      rom_a_q     <= rom_a_d;
      ram_valid_q <= ram_valid_d;
      ram_a_q     <= ram_a_d;
      ram_d_q     <= ram_d_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      x_q         <= x_d;
      y_q         <= y_d;
      cmd_q       <= cmd_d;
    end
  end

  // Image buffer: filled during load, window-updated by pixel commands.
  always_ff @(posedge clk) begin
    if (load_we) mem[rom_a_q] <= IROM_Q;
    if (win_we) begin
      mem[a0] <= n0;
      mem[a1] <= n1;
      mem[a2] <= n2;
      mem[a3] <= n3;
    end
  end

endmodule

// File: tb/tb_lcd_ctrl.sv
// Testbench for lcd_ctrl: IROM/IRAM models, image model and IRAM write scoreboard.
module tb_lcd_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] cmd;
  logic       cmd_valid;
  logic       IROM_rd;
  logic [5:0] IROM_A;
  logic [7:0] IROM_Q;
  logic       IRAM_valid;
  logic [7:0] IRAM_D;
  logic [5:0] IRAM_A;
  logic       busy;
  logic       done;

  lcd_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .cmd        (cmd),
    .cmd_valid  (cmd_valid),
    .IROM_rd    (IROM_rd),
    .IROM_A     (IROM_A),
    .IROM_Q     (IROM_Q),
    .IRAM_valid (IRAM_valid),
    .IRAM_D     (IRAM_D),
    .IRAM_A     (IRAM_A),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] a;
    logic [7:0] d;
  } wr_t;

  logic [7:0] rom  [64];
  logic [7:0] iram [64];
  logic [7:0] img  [64];
  int         mx, my;
  int         total = 0;
  int         bad   = 0;
  wr_t        exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // IROM model: data updates on falling edge from the address presented then.
  always @(negedge clk) begin
    if (IROM_rd) IROM_Q = rom[IROM_A];
  end

  // IRAM model plus scoreboard pop for every write strobe.
  always @(negedge clk) begin
    if (reset === 1'b1 && IRAM_valid === 1'b1) begin
      wr_t e;
      iram[IRAM_A] = IRAM_D;
      if (exp_q.size() == 0) begin
        check("iram_unexpected_write", {26'd0, IRAM_A}, 32'hffff_ffff);
      end else begin
        e = exp_q.pop_front();
        check("iram_addr", {26'd0, IRAM_A}, {26'd0, e.a});
        check("iram_data", {24'd0, IRAM_D}, {24'd0, e.d});
      end
    end
  end

  task automatic wait_idle(input int lim);
    int n = 0;
    while (busy !== 1'b0 && n < lim) begin
      @(negedge clk);
      n++;
    end
    check("wait_idle", {31'd0, busy}, 32'd0);
  endtask

  // Reference model of one command on the bench's own image copy.
  task automatic model_apply(input logic [3:0] c);
    logic [7:0] w [4];
    logic [7:0] n [4];
    int         ad [4];
    int         s;
    ad[0] = (my - 1) * 8 + (mx - 1);
    ad[1] = (my - 1) * 8 + mx;
    ad[2] = my * 8 + (mx - 1);
    ad[3] = my * 8 + mx;
    for (int i = 0; i < 4; i++) begin
      w[i] = img[ad[i]];
      n[i] = w[i];
    end
    case (c)
      4'h1: if (my > 1) my--;
      4'h2: if (my < 7) my++;
      4'h3: if (mx > 1) mx--;
      4'h4: if (mx < 7) mx++;
      4'h5: begin
        s = 0;
        for (int i = 0; i < 4; i++) if (w[i] > s) s = w[i];
        for (int i = 0; i < 4; i++) n[i] = s[7:0];
      end
      4'h6: begin
        s = 255;
        for (int i = 0; i < 4; i++) if (w[i] < s) s = w[i];
        for (int i = 0; i < 4; i++) n[i] = s[7:0];
      end
      4'h7: begin
        s = (w[0] + w[1] + w[2] + w[3]) / 4;
        for (int i = 0; i < 4; i++) n[i] = s[7:0];
      end
      4'h8: begin n[0] = w[1]; n[1] = w[3]; n[2] = w[0]; n[3] = w[2]; end
      4'h9: begin n[0] = w[2]; n[1] = w[0]; n[2] = w[3]; n[3] = w[1]; end
      4'hA: begin n[0] = w[2]; n[1] = w[3]; n[2] = w[0]; n[3] = w[1]; end
      4'hB: begin n[0] = w[1]; n[1] = w[0]; n[2] = w[3]; n[3] = w[2]; end
      default: ;
    endcase
    for (int i = 0; i < 4; i++) img[ad[i]] = n[i];
  endtask

  task automatic issue(input logic [3:0] c);
    wait_idle(20);
    cmd       = c;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("busy_after_cmd", {31'd0, busy}, 32'd1);
    model_apply(c);
    if (c != 4'h0) begin
      @(negedge clk);
      check("exec_one_cycle", {31'd0, busy}, 32'd0);
    end
  endtask

  task automatic load_image();
    @(negedge clk);
    #2 reset = 1'b0;
    cmd_valid = 1'b0;
    exp_q.delete();
    @(negedge clk);
    reset = 1'b1;
    img = rom;
    mx  = 4;
    my  = 4;
    wait_idle(100);
  endtask

  task automatic do_write();
    int n = 0;
    for (int k = 0; k < 64; k++) begin
      wr_t e;
      e.a = k[5:0];
      e.d = img[k];
      exp_q.push_back(e);
    end
    issue(4'h0);
    while (done !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("done_set", {31'd0, done}, 32'd1);
    check("busy_in_done", {31'd0, busy}, 32'd1);
    check("scoreboard_empty", exp_q.size(), 32'd0);
    check("iram_valid_low", {31'd0, IRAM_valid}, 32'd0);
  endtask

  initial begin
    int miss;
    reset     = 1'b0;
    cmd       = 4'h0;
    cmd_valid = 1'b0;
    for (int k = 0; k < 64; k++) rom[k] = 8'($urandom_range(0, 255));

    // Reset values.
    #12;
    check("rst_busy", {31'd0, busy}, 32'd1);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_irom_rd", {31'd0, IROM_rd}, 32'd0);
    check("rst_irom_a", {26'd0, IROM_A}, 32'd0);
    check("rst_iram_valid", {31'd0, IRAM_valid}, 32'd0);
    check("rst_iram_a", {26'd0, IRAM_A}, 32'd0);
    check("rst_iram_d", {24'd0, IRAM_D}, 32'd0);

    // Load then immediate write.
    @(negedge clk);
    reset = 1'b1;
    img = rom;
    mx  = 4;
    my  = 4;
    @(negedge clk);
    check("load_rd", {31'd0, IROM_rd}, 32'd1);
    check("load_a0", {26'd0, IROM_A}, 32'd0);
    check("load_busy", {31'd0, busy}, 32'd1);
    wait_idle(100);
    check("load_rd_off", {31'd0, IROM_rd}, 32'd0);
    do_write();
    miss = 0;
    for (int k = 0; k < 64; k++) if (iram[k] !== rom[k]) miss++;
    check("copy_through", miss, 32'd0);

    // Shift saturation toward top-left, then Max.
    for (int k = 0; k < 64; k++) rom[k] = 8'(k * 2);
    load_image();
    for (int i = 0; i < 4; i++) issue(4'h1);
    for (int i = 0; i < 4; i++) issue(4'h3);
    issue(4'h5);
    do_write();
    check("max_a0", {24'd0, iram[0]}, 32'd18);
    check("max_a1", {24'd0, iram[1]}, 32'd18);
    check("max_a8", {24'd0, iram[8]}, 32'd18);
    check("max_a9", {24'd0, iram[9]}, 32'd18);
    check("max_a2_kept", {24'd0, iram[2]}, 32'd4);

    // Average then Min.
    for (int k = 0; k < 64; k++) rom[k] = 8'(k);
    rom[27] = 8'd10; rom[28] = 8'd20; rom[35] = 8'd30; rom[36] = 8'd41;
    load_image();
    issue(4'h7);
    issue(4'h6);
    do_write();
    check("avg_27", {24'd0, iram[27]}, 32'd25);
    check("avg_28", {24'd0, iram[28]}, 32'd25);
    check("avg_35", {24'd0, iram[35]}, 32'd25);
    check("avg_36", {24'd0, iram[36]}, 32'd25);

    // CW then CCW is identity; reserved E; Mirror X.
    rom[27] = 8'd1; rom[28] = 8'd2; rom[35] = 8'd3; rom[36] = 8'd4;
    load_image();
    issue(4'h9);
    issue(4'h8);
    issue(4'hE);
    issue(4'hA);
    do_write();
    check("mx_27", {24'd0, iram[27]}, 32'd3);
    check("mx_28", {24'd0, iram[28]}, 32'd4);
    check("mx_35", {24'd0, iram[35]}, 32'd1);
    check("mx_36", {24'd0, iram[36]}, 32'd2);

    // Mirror Y on the original window.
    load_image();
    issue(4'hB);
    do_write();
    check("my_27", {24'd0, iram[27]}, 32'd2);
    check("my_28", {24'd0, iram[28]}, 32'd1);
    check("my_35", {24'd0, iram[35]}, 32'd4);
    check("my_36", {24'd0, iram[36]}, 32'd3);

    // Saturation at far corner, then clockwise rotate.
    for (int k = 0; k < 64; k++) rom[k] = 8'(k + 100);
    load_image();
    for (int i = 0; i < 5; i++) issue(4'h2);
    for (int i = 0; i < 5; i++) issue(4'h4);
    issue(4'h9);
    do_write();
    check("cw_54", {24'd0, iram[54]}, 32'd162);
    check("cw_55", {24'd0, iram[55]}, 32'd154);
    check("cw_62", {24'd0, iram[62]}, 32'd163);
    check("cw_63", {24'd0, iram[63]}, 32'd155);
    check("cw_53_kept", {24'd0, iram[53]}, 32'd153);

    // Reset in the middle of a write; stray cmd_valid during reload is ignored.
    load_image();
    for (int k = 0; k < 64; k++) begin
      wr_t e;
      e.a = k[5:0];
      e.d = img[k];
      exp_q.push_back(e);
    end
    issue(4'h0);
    repeat (10) @(negedge clk);
    check("mid_write_valid", {31'd0, IRAM_valid}, 32'd1);
    #2 reset = 1'b0;
    #1;
    check("midrst_valid", {31'd0, IRAM_valid}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd1);
    exp_q.delete();
    @(negedge clk);
    reset     = 1'b1;
    img       = rom;
    mx        = 4;
    my        = 4;
    cmd       = 4'h0;
    cmd_valid = 1'b1;
    @(negedge clk);
    check("reload_rd", {31'd0, IROM_rd}, 32'd1);
    check("reload_a0", {26'd0, IROM_A}, 32'd0);
    repeat (10) @(negedge clk);
    cmd_valid = 1'b0;
    wait_idle(100);
    @(negedge clk);
    check("ignored_busy", {31'd0, busy}, 32'd0);
    check("ignored_no_write", {31'd0, IRAM_valid}, 32'd0);
    do_write();
    miss = 0;
    for (int k = 0; k < 64; k++) if (iram[k] !== rom[k]) miss++;
    check("reload_copy", miss, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lcd_ctrl.md
Name: lcd_ctrl

Overview:
- Image-processing controller for an 8x8, 8-bit grayscale image.
- After reset it loads the image from an external image ROM (IROM) into an internal 64-byte buffer.
- It then runs a stream of 4-bit commands on a 2x2 window around a movable operation point.
- A Write command copies the buffer to an external image RAM (IRAM) and raises done.

Parameters:
- None. Image size fixed at 8x8, pixel width 8 bits.

Ports:
- clk  input  1  system clock; all state on rising edge.
- reset  input  1  reset, asynchronous, active-low.
- cmd  input  4  command code, valid when cmd_valid=1.
- cmd_valid  input  1  command strobe; driven only while busy=0.
- IROM_rd  output  1  IROM read enable.
- IROM_A  output  6  IROM address.
- IROM_Q  input  8  IROM data; IROM updates it on falling clk when IROM_rd=1, from the IROM_A value at that edge.
- IRAM_valid  output  1  IRAM write enable; IRAM writes IRAM_D to IRAM_A on falling clk when 1.
- IRAM_D  output  8  IRAM write data.
- IRAM_A  output  6  IRAM write address.
- busy  output  1  1 = not accepting commands.
- done  output  1  1 = image written to IRAM.

Behaviour:
- Reset values: busy=1, done=0, IROM_rd=0, IROM_A=0, IRAM_valid=0, IRAM_A=0, IRAM_D=0, operation point (x,y)=(4,4), state LOAD.
- Addressing: pixel (col c, row r), c,r in 0..7, maps to address r*8+c, row-major.
- Operation point (x,y) lies in 1..7 on each axis. Its window is P0=(x-1,y-1) top-left, P1=(x,y-1) top-right, P2=(x-1,y) bottom-left, P3=(x,y) bottom-right.
- States: LOAD -> IDLE -> EXEC -> IDLE, and IDLE -> WRITE -> DONE.
- LOAD:
  - IROM_rd=1; IROM_A steps 0..63, one address per cycle.
  - Each IROM_Q byte is captured on the rising edge after the falling edge that produced it, into buffer[address at that falling edge].
  - After buffer[63] is captured: IROM_rd=0, busy=0, go to IDLE.
- IDLE: on a rising edge with cmd_valid=1 and busy=0, latch cmd, set busy=1, go to EXEC. cmd_valid while busy=1 is ignored.
- EXEC: one cycle; apply the command on the next rising edge, then busy=0 and return to IDLE.
- Command set:
  - 0 Write: go to WRITE instead of IDLE.
  - 1 Shift Up: y-1, saturate at 1.
  - 2 Shift Down: y+1, saturate at 7.
  - 3 Shift Left: x-1, saturate at 1.
  - 4 Shift Right: x+1, saturate at 7.
  - 5 Max: all four window pixels <= max(P0..P3).
  - 6 Min: all four <= min.
  - 7 Average: all four <= floor((P0+P1+P2+P3)/4); sum held in 10 bits.
  - 8 Counter-clockwise rotate: new P0,P1,P2,P3 = old P1,P3,P0,P2.
  - 9 Clockwise rotate: new P0,P1,P2,P3 = old P2,P0,P3,P1.
  - A Mirror X (vertical flip, swap rows): new P0,P1,P2,P3 = old P2,P3,P0,P1.
  - B Mirror Y (horizontal flip, swap columns): new P0,P1,P2,P3 = old P1,P0,P3,P2.
  - C-F: no operation, still one busy cycle.
- Operation point is unchanged by commands 5-B. Pixel commands never change (x,y).
- WRITE:
  - busy stays 1; IRAM_valid=1 for 64 consecutive cycles.
  - IRAM_A = 0..63 and IRAM_D = buffer[IRAM_A]; both change only on rising edges so they are stable at each falling edge.
  - After address 63: IRAM_valid=0, done=1.
- DONE: done=1 and busy=1 held until reset; further commands ignored.
- Reset asserted at any time, including mid-LOAD or mid-WRITE: immediately returns all outputs and state to reset values. On release, LOAD restarts from address 0.

Test Plan:
- Load + immediate Write:
  - Stimulus: reset, cmd 0.
  - Response: IRAM[k]==IROM[k] for all 64 k; done rises once; busy high through LOAD and WRITE.
- Shift saturation:
  - Stimulus: 4x Shift Up, 4x Shift Left, then Max.
  - Window is addresses 0,1,8,9; image values k*2 at address k give max 18, so IRAM[0,1,8,9]=18, others unchanged.
- Arithmetic:
  - Window values 10,20,30,41 at (4,4); apply Average.
  - Addresses 27,28,35,36 = 25; then Min leaves 25.
- Rotation/mirror identity:
  - Window 1,2,3,4; apply CW then CCW -> 1,2,3,4.
  - Mirror X -> 3,4,1,2.
  - Mirror Y applied to the original -> 2,1,4,3.
- Saturation at far corner:
  - Stimulus: 5x Shift Down, 5x Shift Right, Clockwise.
  - Window is addresses 54,55,62,63, rotated clockwise; nothing else changes.
- Handshake and reset:
  - Commands issued only when busy=0; reserved cmd E -> one busy cycle, no change.
  - Reset mid-WRITE -> IRAM_valid=0, done=0, reload restarts at IROM_A=0.
